// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: raw key levels and live time from the key/counter side,
// counter controls, display value and lap status back from the controller.
//   key_start/key_reset/key_record/key_load : raw asynchronous key levels, active-high
//   time_in   : live count from the BCD time counter
//   cnt_en, cnt_rst, load : counter enable, synchronous clear, one-cycle preset-load strobe
//   disp_out  : value for display (live time or selected lap)
//   view_mode : 1 when disp_out shows a lap entry
//   lap_count : number of valid laps; lap_full : lap_count == LAP_DEPTH
// Modports: master = key/counter side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned LAP_DEPTH = 8
);
  localparam int unsigned ADDR_W = $clog2(LAP_DEPTH);

  logic              key_start;
  logic              key_reset;
  logic              key_record;
  logic              key_load;
  logic [DATA_W-1:0] time_in;
  logic              cnt_en;
  logic              cnt_rst;
  logic              load;
  logic [DATA_W-1:0] disp_out;
  logic              view_mode;
  logic [ADDR_W:0]   lap_count;
  logic              lap_full;

  modport master (
    output key_start, key_reset, key_record, key_load, time_in,
    input  cnt_en, cnt_rst, load, disp_out, view_mode, lap_count, lap_full
  );

  modport slave (
    input  key_start, key_reset, key_record, key_load, time_in,
    output cnt_en, cnt_rst, load, disp_out, view_mode, lap_count, lap_full
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronises the push keys into one-cycle commands, runs the
// IDLE/RUN/STOP state machine driving the time counter, and keeps a lap buffer that can be
// browsed on the display while stopped.
//   clk  : system clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : stopwatch_ctrl_if slave (keys, time_in in; counter controls, display, lap status out)
module stopwatch_ctrl #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned LAP_DEPTH = 8,
  parameter bit          LAP_WRAP  = 1'b0
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(LAP_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;
  typedef enum logic [2:0] {CmdNone, CmdStart, CmdReset, CmdRecord, CmdLoad} cmd_e;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(LAP_DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Key bit order: {start, reset, record, load}
  logic [3:0] keys, sync1_q, sync2_q, prev_q, pulse;
  cmd_e       cmd;
  state_e     state_q, state_d;

  logic              cnt_en_q, cnt_rst_q, load_q, view_q;
  logic [DATA_W-1:0] disp_q;
  logic [ADDR_W-1:0] wr_ptr_q, oldest_q, idx_q, rd_addr;
  logic [ADDR_W:0]   lap_count_q, rd_sum;
  logic              lap_full, lap_wr, browse;
  logic [DATA_W-1:0] lap_mem [LAP_DEPTH];

  assign keys  = {bus.key_start, bus.key_reset, bus.key_record, bus.key_load};
  assign pulse = sync2_q & ~prev_q;

  // Single command per cycle; lower-priority pulses in the same cycle are dropped
  always_comb begin
    cmd = CmdNone;
    if (pulse[3])      cmd = CmdStart;
    else if (pulse[2]) cmd = CmdReset;
    else if (pulse[1]) cmd = CmdRecord;
    else if (pulse[0]) cmd = CmdLoad;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd == CmdStart) state_d = StRun;
      StRun:  if (cmd == CmdStart) state_d = StStop;
      StStop: begin
        if (cmd == CmdStart)      state_d = StRun;
        else if (cmd == CmdReset) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign lap_full = (lap_count_q == (ADDR_W+1)'(LAP_DEPTH));
  assign lap_wr   = (cmd == CmdRecord) && (state_q == StRun) && (!lap_full || LAP_WRAP);
  assign browse   = (cmd == CmdRecord) && (state_q == StStop) && (lap_count_q != '0);

  // Browse index is relative to the oldest entry; fold back into the circular buffer
  always_comb begin
    rd_sum = {1'b0, oldest_q} + {1'b0, idx_q};
    if (rd_sum >= (ADDR_W+1)'(LAP_DEPTH)) rd_sum = rd_sum - (ADDR_W+1)'(LAP_DEPTH);
    rd_addr = rd_sum[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      state_q     <= StIdle;
      cnt_en_q    <= 1'b0;
      cnt_rst_q   <= 1'b1;
      load_q      <= 1'b0;
      disp_q      <= '0;
      view_q      <= 1'b0;
      wr_ptr_q    <= '0;
      oldest_q    <= '0;
      idx_q       <= '0;
      lap_count_q <= '0;
    end else begin
      sync1_q   <= keys;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_en_q  <= (state_d == StRun);
      cnt_rst_q <= (state_d == StIdle);
      load_q    <= (cmd == CmdLoad) && (state_q == StIdle);
      disp_q    <= view_q ? lap_mem[rd_addr] : bus.time_in;

      if ((state_q == StStop) && (cmd == CmdReset)) begin
        wr_ptr_q    <= '0;
        oldest_q    <= '0;
        idx_q       <= '0;
        lap_count_q <= '0;
        view_q      <= 1'b0;
      end else if ((state_q == StStop) && (cmd == CmdStart)) begin
        view_q <= 1'b0;
      end else if (lap_wr) begin
        wr_ptr_q <= wrap_inc(wr_ptr_q);
        // When full the write slot is the oldest entry, so the oldest moves on
        if (lap_full) oldest_q    <= wrap_inc(oldest_q);
        else          lap_count_q <= lap_count_q + (ADDR_W+1)'(1);
      end else if (browse) begin
        if (!view_q) begin
          view_q <= 1'b1;
          idx_q  <= '0;
        end else if (({1'b0, idx_q} + (ADDR_W+1)'(1)) == lap_count_q) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + ADDR_W'(1);
        end
      end
    end
  end

  // Lap storage is not reset; validity is tracked by lap_count only
  always_ff @(posedge clk) begin
    if (lap_wr && !rst) lap_mem[wr_ptr_q] <= bus.time_in;
  end

  assign bus.cnt_en    = cnt_en_q;
  assign bus.cnt_rst   = cnt_rst_q;
  assign bus.load      = load_q;
  assign bus.disp_out  = disp_q;
  assign bus.view_mode = view_q;
  assign bus.lap_count = lap_count_q;
  assign bus.lap_full  = lap_full;
endmodule
